data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
- REQ-001: Parameters SHALL be: DEPTH, default 1024, memory size in 32-bit words (power of two); BASE_ADDR, default 32'h8000_0000, byte address of word 0; LATENCY, default 2, cycles from request accept to rsp_valid (>=1).
- REQ-002: clk  input  1  single clock, all state on rising edge.
- REQ-003: rst_n  input  1  asynchronous active-low reset.
- REQ-004: req_valid  input  1  request present (LSU side, from ex_lsu_t mem_en && valid).
- REQ-005: req_ready  output  1  responder can accept a request.
- REQ-006: req_wen  input  1  1=store, 0=load.
- REQ-007: req_addr  input  32  byte address.
- REQ-008: req_wdata  input  32  store data, byte/half in low bits.
- REQ-009: req_funct3  input  3  RV32 load/store width code.
- REQ-010: rsp_valid  output  1  response present.
- REQ-011: rsp_ready  input  1  LSU accepts response.
- REQ-012: rsp_rdata  output  32  extended load data; 0 for stores and faults.
- REQ-013: rsp_err  output  1  access fault.

Function
- REQ-014: FSM SHALL have states IDLE, WAIT, RESP; one outstanding transaction.
- REQ-015: req_ready SHALL be 1 only in IDLE; request accepted on req_valid && req_ready; addr, wen, wdata, funct3 latched.
- REQ-016: On accept, LATENCY==1 SHALL go IDLE->RESP; otherwise IDLE->WAIT with counter loaded LATENCY-2, WAIT->RESP when counter==0, decrement otherwise.
- REQ-017: rsp_valid SHALL be 1 exactly in RESP; rsp_rdata/rsp_err stable while rsp_valid && !rsp_ready.
- REQ-018: RESP->IDLE on rsp_ready; no new accept in that cycle (req_ready rises next cycle).
- REQ-019: Loads: funct3 000 LB sign-extend, 001 LH sign-extend, 010 LW, 100 LBU zero-extend, 101 LHU zero-extend; byte lane from addr[1:0].
- REQ-020: Stores: funct3 000 SB, 001 SH, 010 SW; only addressed byte lanes written.
- REQ-021: Store write SHALL commit on the WAIT/IDLE->RESP transition edge, once per transaction.
- REQ-022: Word index SHALL be (addr-BASE_ADDR)>>2, modulo 2^32 arithmetic.
- REQ-023: Fault conditions (feature enabled): index>=DEPTH, half misaligned (addr[0]!=0), word misaligned (addr[1:0]!=0), funct3 not listed for the access type; fault SHALL suppress the write and force rdata 0, err 1.
- REQ-024: Latency SHALL be identical for faulting and non-faulting accesses.

Reset
- REQ-025: rst_n low SHALL force IDLE, counter 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, req_ready 1 after release.
- REQ-026: Reset mid-transaction SHALL drop it; an uncommitted store SHALL not write memory.
- REQ-027: Memory array contents SHALL NOT be reset.

Configuration
- REQ-028: Macro DMEM_ACCESS_FAULT_EN defined: REQ-023 checks active.
- REQ-029: Undefined: rsp_err tied 0; index wraps modulo DEPTH; addr[1:0] forced to 0 for half/word (halves use addr[1]); undefined funct3 treated as word access.

Structure
- REQ-030: cpu_types_pkg SHALL gain mem_req_t (wen, addr, wdata, funct3, valid), mem_rsp_t (rdata, err, valid), and funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
- REQ-031: One combinational sub-module dmem_lane_align SHALL compute write byte strobes, shifted write data, and extended read data from funct3 and addr[1:0].

Verification
- REQ-032: SW 0xDEADBEEF @0x8000_0000, then LW @0x8000_0000, LATENCY=2 -> rsp_valid 2 cycles after each accept, load rdata 0xDEADBEEF, err 0.
- REQ-033: After REQ-032, LB @0x8000_0003 -> 0xFFFFFFDE; LBU -> 0x000000DE; LHU @0x8000_0002 -> 0x0000DEAD.
- REQ-034: SB 0x12 @0x8000_0001 then LW -> 0xDEAD12EF.
- REQ-035: Enabled: LW @0x8000_0002 -> err 1, rdata 0, memory unchanged; SW @BASE+DEPTH*4 -> err 1, no write.
- REQ-036: rsp_ready held 0 for 5 cycles -> rsp_valid/rdata stable, req_ready 0 throughout.
- REQ-037: rst_n asserted in WAIT of SW 0x55 @0x8000_0010 -> rsp_valid 0, later LW @0x8000_0010 returns prior value.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-interface types, funct3 width codes and access-size decode helpers
// used by the data memory responder and its lane aligner.
package cpu_types_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef struct packed {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  funct3;
    logic        valid;
  } mem_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        valid;
  } mem_rsp_t;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} acc_size_e;

  // Codes not listed for the access type fall back to a word access.
  function automatic acc_size_e f3_size(input logic wen, input logic [2:0] f3);
    acc_size_e s;
    s = SZ_W;
    if (f3 == F3_B || (!wen && f3 == F3_BU))      s = SZ_B;
    else if (f3 == F3_H || (!wen && f3 == F3_HU)) s = SZ_H;
    return s;
  endfunction

  function automatic logic f3_legal(input logic wen, input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (!wen && ((f3 == F3_BU) || (f3 == F3_HU)));
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: write strobes, shifted store data and
// sign/zero-extended load data from funct3 and the low address bits.
module dmem_lane_align
  import cpu_types_pkg::*;
(
  input  logic        i_wen,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  acc_size_e   w_size;
  logic [1:0]  w_off;
  logic        w_sext;
  logic [31:0] w_rsh;

  // Halves only honour addr[1] and words start at lane 0, so a misaligned
  // access is silently realigned when no fault checking is in front of this.
  always_comb begin
    w_size = f3_size(i_wen, i_funct3);
    w_sext = ~i_funct3[2];
    unique case (w_size)
      SZ_B: begin
        w_off   = i_addr_lo;
        o_wstrb = 4'b0001 << w_off;
      end
      SZ_H: begin
        w_off   = {i_addr_lo[1], 1'b0};
        o_wstrb = 4'b0011 << w_off;
      end
      default: begin
        w_off   = '0;
        o_wstrb = '1;
      end
    endcase
    o_wdata = i_wdata << {w_off, 3'b000};
    w_rsh   = i_rword >> {w_off, 3'b000};
    unique case (w_size)
      SZ_B:    o_rdata = {{24{w_sext & w_rsh[7]}}, w_rsh[7:0]};
      SZ_H:    o_rdata = {{16{w_sext & w_rsh[15]}}, w_rsh[15:0]};
      default: o_rdata = w_rsh;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding data memory responder with fixed request-to-response latency.
// Define DMEM_ACCESS_FAULT_EN to enable range/alignment/funct3 access-fault checks.
module data_mem_responder
  import cpu_types_pkg::*;
#(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e      r_state, w_state_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  mem_req_t    r_req, w_cur;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_mem [DEPTH];

  logic        w_accept, w_commit, w_fault;
  logic [31:0] w_widx;
  logic [AW-1:0] w_idx;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata_sh, w_rdata_ext;
  logic        w_unused_bits;

  assign req_ready = (r_state == IDLE);
  assign rsp_valid = (r_state == RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;
  assign w_accept  = req_valid && req_ready;

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    unique case (r_state)
      IDLE: if (w_accept) begin
        if (LATENCY == 1) w_state_nx = RESP;
        else begin
          w_state_nx = WAIT;
          w_cnt_nx   = CW'(LATENCY - 2);
        end
      end
      WAIT: if (r_cnt == '0) w_state_nx = RESP;
            else             w_cnt_nx   = r_cnt - 1'b1;
      RESP: if (rsp_ready) w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  // With LATENCY==1 the commit edge is the accept edge, so the live request
  // is used there instead of the latched copy.
  always_comb begin
    if (r_state == IDLE)
      w_cur = '{wen: req_wen, addr: req_addr, wdata: req_wdata,
                funct3: req_funct3, valid: req_valid};
    else
      w_cur = r_req;
  end

  assign w_commit      = (w_state_nx == RESP) && (r_state != RESP);
  assign w_widx        = (w_cur.addr - BASE_ADDR) >> 2;
  assign w_idx         = w_widx[AW-1:0];
  assign w_unused_bits = ^{w_cur.valid, w_widx};

`ifdef DMEM_ACCESS_FAULT_EN
  always_comb begin
    w_fault = (w_widx >= 32'(DEPTH)) || !f3_legal(w_cur.wen, w_cur.funct3);
    unique case (f3_size(w_cur.wen, w_cur.funct3))
      SZ_H:    w_fault = w_fault || w_cur.addr[0];
      SZ_W:    w_fault = w_fault || (w_cur.addr[1:0] != 2'b00);
      default: w_fault = w_fault;
    endcase
  end
`else
  assign w_fault = 1'b0;
`endif

  dmem_lane_align u_lane_align (
    .i_wen     (w_cur.wen),
    .i_funct3  (w_cur.funct3),
    .i_addr_lo (w_cur.addr[1:0]),
    .i_wdata   (w_cur.wdata),
    .i_rword   (r_mem[w_idx]),
    .o_wstrb   (w_wstrb),
    .o_wdata   (w_wdata_sh),
    .o_rdata   (w_rdata_ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_req   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      if (w_accept) r_req <= w_cur;
      if (w_commit) begin
        r_rdata <= (w_fault || w_cur.wen) ? '0 : w_rdata_ext;
        r_err   <= w_fault;
      end
    end
  end

  // Array is deliberately not reset; rst_n gating keeps a held reset from writing.
  always_ff @(posedge clk) begin
    if (w_commit && rst_n && w_cur.wen && !w_fault) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (w_wstrb[b]) r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder (DEPTH=64, LATENCY=2); fault-path
// expectations follow DMEM_ACCESS_FAULT_EN.
module tb_data_mem_responder;
  import cpu_types_pkg::*;

  localparam int unsigned DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_wen = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [2:0]  req_funct3 = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [31:0] rsp_rdata;

  data_mem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    string       name;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [31:0] er;
    logic        ee;
  } vec_t;

  exp_t        sb_q[$];
  int unsigned n_checks = 0, n_bad = 0;
  logic [31:0] o_rd;
  logic        o_err, o_rdy, o_vld;
  int          o_lat;
  logic [7:0]  bmem [64];

  function automatic vec_t mk(input string n, input logic w, input logic [31:0] a,
                              input logic [31:0] d, input logic [2:0] f,
                              input logic [31:0] er, input logic ee);
    vec_t v;
    v.name = n; v.wen = w; v.addr = a; v.wdata = d; v.f3 = f; v.er = er; v.ee = ee;
    return v;
  endfunction

  // Drives one transaction and records the observed response and timing.
  task automatic issue(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] f3, input logic [31:0] er, input logic ee);
    int n;
    exp_t e;
    e.rdata = er; e.err = ee;
    sb_q.push_back(e);
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata; req_funct3 = f3;
    n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    o_lat = 1;
    while (!rsp_valid && o_lat < 50) begin @(posedge clk); #1; o_lat++; end
    o_rd = rsp_rdata; o_err = rsp_err;
    if (rsp_valid) begin
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
    end
    o_rdy = req_ready; o_vld = rsp_valid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0 || req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset: valid=%b rdata=%h err=%b ready=%b, expected 0/00000000/0/1",
               rsp_valid, rsp_rdata, rsp_err, req_ready);
    end
  endtask

  task automatic test_load_store();
    vec_t v[$];
    exp_t e;
    v.push_back(mk("sw_deadbeef", 1, BASE,     32'hDEADBEEF, F3_W,  32'h0, 0));
    v.push_back(mk("lw_word0",    0, BASE,     32'h0,        F3_W,  32'hDEADBEEF, 0));
    v.push_back(mk("lb_3",        0, BASE+3,   32'h0,        F3_B,  32'hFFFFFFDE, 0));
    v.push_back(mk("lbu_3",       0, BASE+3,   32'h0,        F3_BU, 32'h000000DE, 0));
    v.push_back(mk("lhu_2",       0, BASE+2,   32'h0,        F3_HU, 32'h0000DEAD, 0));
    v.push_back(mk("lh_2",        0, BASE+2,   32'h0,        F3_H,  32'hFFFFDEAD, 0));
    v.push_back(mk("sb_12_at1",   1, BASE+1,   32'hFFFFFF12, F3_B,  32'h0, 0));
    v.push_back(mk("lw_after_sb", 0, BASE,     32'h0,        F3_W,  32'hDEAD12EF, 0));
    v.push_back(mk("lb_1",        0, BASE+1,   32'h0,        F3_B,  32'h00000012, 0));
    v.push_back(mk("sw_word1",    1, BASE+4,   32'h00000000, F3_W,  32'h0, 0));
    v.push_back(mk("sh_at6",      1, BASE+6,   32'hA5A58001, F3_H,  32'h0, 0));
    v.push_back(mk("lw_word1",    0, BASE+4,   32'h0,        F3_W,  32'h80010000, 0));
    v.push_back(mk("lh_6",        0, BASE+6,   32'h0,        F3_H,  32'hFFFF8001, 0));
    v.push_back(mk("lhu_4",       0, BASE+4,   32'h0,        F3_HU, 32'h00000000, 0));
    for (int i = 0; i < v.size(); i++) begin
      issue(v[i].wen, v[i].addr, v[i].wdata, v[i].f3, v[i].er, v[i].ee);
      e = sb_q.pop_front();
      n_checks++;
      if (o_rd !== e.rdata || o_err !== e.err) begin
        n_bad++;
        $display("FAIL %s: rdata=%h err=%b, expected rdata=%h err=%b",
                 v[i].name, o_rd, o_err, e.rdata, e.err);
      end
      n_checks++;
      if (o_lat !== 2 || o_rdy !== 1'b1 || o_vld !== 1'b0) begin
        n_bad++;
        $display("FAIL %s_timing: latency=%0d ready_after=%b valid_after=%b, expected 2/1/0",
                 v[i].name, o_lat, o_rdy, o_vld);
      end
    end
  endtask

  task automatic test_faults();
    vec_t v[$];
    exp_t e;
`ifdef DMEM_ACCESS_FAULT_EN
    v.push_back(mk("lw_misalign",  0, BASE+2,         32'h0,        F3_W,   32'h0, 1));
    v.push_back(mk("lh_misalign",  0, BASE+1,         32'h0,        F3_H,   32'h0, 1));
    v.push_back(mk("lw_unchanged", 0, BASE,           32'h0,        F3_W,   32'hDEAD12EF, 0));
    v.push_back(mk("sw_oob",       1, BASE+DEPTH*4,   32'h77777777, F3_W,   32'h0, 1));
    v.push_back(mk("sw_below",     1, BASE-4,         32'h66666666, F3_W,   32'h0, 1));
    v.push_back(mk("ld_f3_011",    0, BASE,           32'h0,        3'b011, 32'h0, 1));
    v.push_back(mk("st_f3_100",    1, BASE,           32'h55555555, 3'b100, 32'h0, 1));
    v.push_back(mk("sw_misalign",  1, BASE+2,         32'h44444444, F3_W,   32'h0, 1));
    v.push_back(mk("lw_no_write",  0, BASE,           32'h0,        F3_W,   32'hDEAD12EF, 0));
`else
    v.push_back(mk("lw_realign",   0, BASE+2,         32'h0,        F3_W,   32'hDEAD12EF, 0));
    v.push_back(mk("lhu_realign1", 0, BASE+1,         32'h0,        F3_HU,  32'h000012EF, 0));
    v.push_back(mk("lhu_realign3", 0, BASE+3,         32'h0,        F3_HU,  32'h0000DEAD, 0));
    v.push_back(mk("ld_f3_011",    0, BASE,           32'h0,        3'b011, 32'hDEAD12EF, 0));
    v.push_back(mk("sw_wrap",      1, BASE+DEPTH*4,   32'h77777777, F3_W,   32'h0, 0));
    v.push_back(mk("lw_wrapped",   0, BASE,           32'h0,        F3_W,   32'h77777777, 0));
    v.push_back(mk("sw_realign",   1, BASE+2,         32'hCAFEF00D, F3_W,   32'h0, 0));
    v.push_back(mk("lw_realigned", 0, BASE,           32'h0,        F3_W,   32'hCAFEF00D, 0));
    v.push_back(mk("st_f3_100",    1, BASE+1,         32'h11223344, 3'b100, 32'h0, 0));
    v.push_back(mk("lw_f3_100_st", 0, BASE,           32'h0,        F3_W,   32'h11223344, 0));
`endif
    for (int i = 0; i < v.size(); i++) begin
      issue(v[i].wen, v[i].addr, v[i].wdata, v[i].f3, v[i].er, v[i].ee);
      e = sb_q.pop_front();
      n_checks++;
      if (o_rd !== e.rdata || o_err !== e.err) begin
        n_bad++;
        $display("FAIL %s: rdata=%h err=%b, expected rdata=%h err=%b",
                 v[i].name, o_rd, o_err, e.rdata, e.err);
      end
      n_checks++;
      if (o_lat !== 2) begin
        n_bad++;
        $display("FAIL %s_latency: latency=%0d, expected 2", v[i].name, o_lat);
      end
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    int   n;
    issue(1'b1, BASE+8, 32'h13579BDF, F3_W, 32'h0, 1'b0);
    e = sb_q.pop_front();
    n_checks++;
    if (o_rd !== e.rdata || o_err !== e.err) begin
      n_bad++;
      $display("FAIL bp_store: rdata=%h err=%b, expected %h/%b", o_rd, o_err, e.rdata, e.err);
    end
    e.rdata = 32'h13579BDF; e.err = 1'b0;
    sb_q.push_back(e);
    req_valid = 1'b1; req_wen = 1'b0; req_addr = BASE+8; req_funct3 = F3_W;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
    e = sb_q.pop_front();
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata || rsp_err !== e.err || req_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_hold%0d: valid=%b rdata=%h err=%b ready=%b, expected 1/%h/%b/0",
                 c, rsp_valid, rsp_rdata, rsp_err, req_ready, e.rdata, e.err);
      end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_release: valid=%b ready=%b, expected 0/1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    issue(1'b1, BASE+32'h10, 32'h11223344, F3_W, 32'h0, 1'b0);
    void'(sb_q.pop_front());
    req_valid = 1'b1; req_wen = 1'b1; req_addr = BASE+32'h10;
    req_wdata = 32'h00000055; req_funct3 = F3_W;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    n_checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset: valid=%b rdata=%h err=%b, expected 0/00000000/0",
               rsp_valid, rsp_rdata, rsp_err);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_reset_after: valid=%b ready=%b, expected 0/1", rsp_valid, req_ready);
    end
    issue(1'b0, BASE+32'h10, 32'h0, F3_W, 32'h11223344, 1'b0);
    e = sb_q.pop_front();
    n_checks++;
    if (o_rd !== e.rdata || o_err !== e.err) begin
      n_bad++;
      $display("FAIL mid_reset_noWrite: rdata=%h err=%b, expected %h/%b", o_rd, o_err, e.rdata, e.err);
    end
  endtask

  function automatic logic [31:0] mdl_load(input int unsigned a, input logic [2:0] f3);
    logic [31:0] r;
    case (f3)
      F3_B:    r = {{24{bmem[a][7]}}, bmem[a]};
      F3_BU:   r = {24'h0, bmem[a]};
      F3_H:    r = {{16{bmem[a+1][7]}}, bmem[a+1], bmem[a]};
      F3_HU:   r = {16'h0, bmem[a+1], bmem[a]};
      default: r = {bmem[a+3], bmem[a+2], bmem[a+1], bmem[a]};
    endcase
    return r;
  endfunction

  task automatic test_random();
    exp_t        e;
    logic [31:0] d, er;
    logic [2:0]  f3;
    int unsigned a, nb, sel;
    for (int w = 0; w < 16; w++) begin
      d = $urandom;
      for (int b = 0; b < 4; b++) bmem[w*4+b] = d[8*b +: 8];
      issue(1'b1, BASE + 32'h80 + 32'(w*4), d, F3_W, 32'h0, 1'b0);
      void'(sb_q.pop_front());
    end
    for (int k = 0; k < 40; k++) begin
      sel = $urandom_range(0, 7);
      a   = $urandom_range(0, 63);
      d   = $urandom;
      case (sel)
        0: f3 = F3_B;  1: f3 = F3_H;  2: f3 = F3_W;  3: f3 = F3_BU;
        4: f3 = F3_HU; 5: f3 = F3_B;  6: f3 = F3_H;  default: f3 = F3_W;
      endcase
      nb = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      a  = a - (a % nb);
      if (sel >= 5) begin
        er = 32'h0;
        issue(1'b1, BASE + 32'h80 + 32'(a), d, f3, er, 1'b0);
        for (int b = 0; b < int'(nb); b++) bmem[a+b] = d[8*b +: 8];
      end else begin
        er = mdl_load(a, f3);
        issue(1'b0, BASE + 32'h80 + 32'(a), d, f3, er, 1'b0);
      end
      e = sb_q.pop_front();
      n_checks++;
      if (o_rd !== e.rdata || o_err !== e.err || o_lat !== 2) begin
        n_bad++;
        $display("FAIL rand%0d op%0d addr+%0d: rdata=%h err=%b lat=%0d, expected %h/%b/2",
                 k, sel, a, o_rd, o_err, o_lat, e.rdata, e.err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_store();
    test_faults();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1);
  end

endmodule
